alu_packet_sequencer: RTL and testbench

Sequences the UART ALU datapath for one packet at a time. Parses byte packets arriving from the UART receiver and issues word-wide operations to the ALU through a multicycle request/done handshake. Accumulates the running result, then streams the response bytes to the UART transmitter. It sits between uart_rx/uart_tx and the alu on the ice40 top level.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/word_assembler.sv | 51 +++++
 rtl/alu_packet_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_packet_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, header size and sequencer state encoding
// for the UART ALU packet path.
package alu_pkg;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;
    localparam logic [7:0] OP_MUL  = 8'hAC;
    localparam logic [7:0] OP_DIV  = 8'hD1;

    localparam int HDR_BYTES = 4;

    typedef enum logic [3:0] {
        HDR0,
        HDR1,
        HDR2,
        HDR3,
        COLLECT,
        ALU_WAIT,
        ECHO,
        RESP,
        DRAIN
    } seq_state_e;

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word assembler; word_valid pulses
// combinationally on the byte that completes a word.
module word_assembler #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              word_valid,
    output logic [DATA_W-1:0] word
);

    localparam int BPW = DATA_W / 8;
    localparam int CW  = $clog2(BPW + 1);

    logic [CW-1:0] cnt;

    assign word_valid = byte_valid && (cnt == CW'(BPW - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (byte_valid) begin
            cnt <= word_valid ? '0 : cnt + CW'(1);
        end
    end

    if (BPW > 1) begin : g_multi
        // Earlier bytes; the incoming byte supplies the top lane.
        logic [DATA_W-9:0] sr;

        assign word = {byte_data, sr};

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sr <= '0;
            end else if (clear) begin
                sr <= '0;
            end else if (byte_valid) begin
                sr <= word[DATA_W-1:8];
            end
        end
    end else begin : g_single
        assign word = byte_data;
    end

endmodule

// File: rtl/alu_packet_sequencer.sv
// Parses UART packets, drives the multicycle ALU handshake
// and streams the accumulated result back out.
module alu_packet_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic [7:0]        alu_opcode_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic              alu_valid_o,
    input  logic              alu_done_i,
    input  logic [DATA_W-1:0] alu_result_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int BPW = DATA_W / 8;
    localparam int IW  = $clog2(BPW + 1);

    seq_state_e state, state_n;

    logic [7:0]        opcode, len_lo, resp_lsb, acc_byte;
    logic [LEN_W-1:0]  rem, words_left;
    logic [LEN_W-1:0]  len_full, payload, nwords;
    logic [DATA_W-1:0] acc, dividend, acc_init, word;
    logic [IW-1:0]     tx_idx, tx_idx_nxt;
    logic              widx, ready_c, rx_fire, tx_fire;
    logic              hdr_bad, word_valid, asm_in, last_tx;

    assign rx_ready_o = rst & ready_c;
    assign rx_fire    = rx_valid_i & rx_ready_o;
    assign tx_fire    = tx_valid_o & tx_ready_i;

    assign len_full = LEN_W'({rx_data_i, len_lo});
    assign payload  = (len_full < LEN_W'(HDR_BYTES)) ? '0
                    : len_full - LEN_W'(HDR_BYTES);
    assign nwords   = payload / LEN_W'(BPW);

    assign acc_init   = DATA_W'(opcode == OP_MUL);
    assign asm_in     = (state == COLLECT) && rx_fire
                     && (words_left != '0);
    assign tx_idx_nxt = tx_idx + IW'(1);
    assign last_tx    = (tx_idx == IW'(BPW - 1));

    word_assembler #(.DATA_W(DATA_W)) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == HDR3),
        .byte_valid (asm_in),
        .byte_data  (rx_data_i),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        acc_byte = '0;
        for (int i = 0; i < BPW; i++) begin
            if (tx_idx_nxt == IW'(i)) acc_byte = acc[8*i +: 8];
        end
    end

    always_comb begin
        resp_lsb = acc[7:0];
        if (state == ALU_WAIT) resp_lsb = alu_result_i[7:0];
        else if (state == HDR3) resp_lsb = acc_init[7:0];
    end

    // Echo stalls rx while a byte waits for the transmitter.
    always_comb begin
        ready_c = 1'b0;
        case (state)
            HDR0, HDR1, HDR2, HDR3, COLLECT, DRAIN: ready_c = 1'b1;
            ECHO:    ready_c = !tx_valid_o;
            default: ready_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= HDR0;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        hdr_bad = 1'b0;
        case (state)
            HDR0: if (rx_fire) state_n = HDR1;
            HDR1: if (rx_fire) state_n = HDR2;
            HDR2: if (rx_fire) state_n = HDR3;
            HDR3: begin
                if (rx_fire) begin
                    unique case (1'b1)
                        opcode == OP_ECHO:
                            state_n = (payload == '0) ? HDR0 : ECHO;
                        opcode == OP_ADD, opcode == OP_MUL:
                            state_n = (payload == '0) ? RESP : COLLECT;
                        opcode == OP_DIV && nwords == LEN_W'(2):
                            state_n = COLLECT;
                        default: begin
                            hdr_bad = 1'b1;
                            state_n = (payload == '0) ? HDR0 : DRAIN;
                        end
                    endcase
                end
            end
            COLLECT: begin
                if (rx_fire) begin
                    if (words_left == '0) begin
                        if (rem == LEN_W'(1)) state_n = RESP;
                    end else if (word_valid &&
                                 !(opcode == OP_DIV && !widx)) begin
                        state_n = ALU_WAIT;
                    end
                end
            end
            ALU_WAIT: begin
                if (alu_done_i)
                    state_n = (rem == '0) ? RESP : COLLECT;
            end
            ECHO: if (tx_fire && rem == '0) state_n = HDR0;
            RESP: if (tx_fire && last_tx) state_n = HDR0;
            DRAIN: if (rx_fire && rem == LEN_W'(1)) state_n = HDR0;
            default: state_n = HDR0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opcode       <= '0;
            len_lo       <= '0;
            rem          <= '0;
            words_left   <= '0;
            acc          <= '0;
            dividend     <= '0;
            widx         <= 1'b0;
            tx_idx       <= '0;
            tx_data_o    <= '0;
            tx_valid_o   <= 1'b0;
            alu_opcode_o <= '0;
            alu_a_o      <= '0;
            alu_b_o      <= '0;
            alu_valid_o  <= 1'b0;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            err_o <= 1'b0;
            if (state_n == HDR0 && state != HDR0) busy_o <= 1'b0;
            // First response byte is loaded on the entering edge.
            if (state_n == RESP && state != RESP) begin
                tx_valid_o <= 1'b1;
                tx_idx     <= '0;
                tx_data_o  <= resp_lsb;
            end
            case (state)
                HDR0: begin
                    if (rx_fire) begin
                        opcode <= rx_data_i;
                        busy_o <= 1'b1;
                    end
                end
                HDR2: if (rx_fire) len_lo <= rx_data_i;
                HDR3: begin
                    if (rx_fire) begin
                        rem        <= payload;
                        words_left <= nwords;
                        widx       <= 1'b0;
                        acc        <= acc_init;
                        err_o      <= hdr_bad;
                    end
                end
                COLLECT: begin
                    if (rx_fire) begin
                        rem <= rem - LEN_W'(1);
                        if (word_valid) begin
                            words_left <= words_left - LEN_W'(1);
                            if (opcode == OP_DIV && !widx) begin
                                dividend <= word;
                                widx     <= 1'b1;
                            end else begin
                                alu_valid_o  <= 1'b1;
                                alu_opcode_o <= opcode;
                                alu_a_o      <= (opcode == OP_DIV)
                                              ? dividend : acc;
                                alu_b_o      <= word;
                            end
                        end
                    end
                end
                ALU_WAIT: begin
                    if (alu_done_i) begin
                        alu_valid_o <= 1'b0;
                        acc         <= alu_result_i;
                    end
                end
                ECHO: begin
                    if (rx_fire) begin
                        tx_data_o  <= rx_data_i;
                        tx_valid_o <= 1'b1;
                        rem        <= rem - LEN_W'(1);
                    end
                    if (tx_fire) tx_valid_o <= 1'b0;
                end
                RESP: begin
                    if (tx_fire) begin
                        if (last_tx) begin
                            tx_valid_o <= 1'b0;
                        end else begin
                            tx_idx    <= tx_idx_nxt;
                            tx_data_o <= acc_byte;
                        end
                    end
                end
                DRAIN: if (rx_fire) rem <= rem - LEN_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_packet_sequencer.sv
// Table-driven bench with a tx scoreboard and a latency-
// configurable ALU stub; reset-mid-packet sequence by hand.
module tb_alu_packet_sequencer;

    typedef struct packed {
        logic [7:0]        op;
        logic [15:0]       len;
        logic [7:0]        npl;
        logic [15:0][7:0]  pl;
        logic [7:0]        nex;
        logic [7:0][7:0]   ex;
        logic [7:0]        na;
        logic [2:0][31:0]  ea;
        logic [2:0][31:0]  eb;
        logic              err;
        logic [7:0]        lat;
        logic              tog;
    } vec_t;

    localparam int NV = 16;

    logic        clk, rst;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  alu_opcode;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_valid, alu_done;
    logic        busy, err;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    int wait_cnt = 0;
    int alu_lat = 1;
    bit tog = 1'b0;
    logic [7:0]  exp_q[$];
    logic [31:0] got_a[$];
    logic [31:0] got_b[$];
    vec_t vecs[NV];

    alu_packet_sequencer #(.DATA_W(32), .LEN_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data_i    (rx_data),
        .rx_valid_i   (rx_valid),
        .rx_ready_o   (rx_ready),
        .tx_data_o    (tx_data),
        .tx_valid_o   (tx_valid),
        .tx_ready_i   (tx_ready),
        .alu_opcode_o (alu_opcode),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_valid_o  (alu_valid),
        .alu_done_i   (alu_done),
        .alu_result_i (alu_result),
        .busy_o       (busy),
        .err_o        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s got=timeout required=progress", nm);
    endtask

    function automatic vec_t mk(
        input logic [7:0] op, input logic [15:0] len,
        input logic [7:0] npl, input logic [127:0] pl,
        input logic [7:0] nex, input logic [63:0] ex,
        input logic [7:0] na, input logic [95:0] ea,
        input logic [95:0] eb, input logic e,
        input logic [7:0] lat, input logic tg);
        vec_t v;
        v.op = op;   v.len = len; v.npl = npl; v.pl = pl;
        v.nex = nex; v.ex = ex;   v.na = na;   v.ea = ea;
        v.eb = eb;   v.err = e;   v.lat = lat; v.tog = tg;
        return v;
    endfunction

    // ALU stub: answers each request after alu_lat cycles.
    initial begin
        alu_done = 1'b0;
        alu_result = '0;
        forever begin
            @(negedge clk);
            alu_done = 1'b0;
            if (!rst || !alu_valid) begin
                wait_cnt = 0;
            end else if (wait_cnt >= alu_lat - 1) begin
                case (alu_opcode)
                    8'hAD: alu_result = alu_a + alu_b;
                    8'hAC: alu_result = alu_a * alu_b;
                    8'hD1: alu_result = (alu_b == 0) ? '1
                                      : alu_a / alu_b;
                    default: alu_result = '0;
                endcase
                got_a.push_back(alu_a);
                got_b.push_back(alu_b);
                alu_done = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end
    end

    // TX sink and scoreboard pop.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            tx_ready = tog ? ~tx_ready : 1'b1;
            if (rst && tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected got=%0h required=none",
                             tx_data);
                end else begin
                    chk("tx_byte", 64'(tx_data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (err) err_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data = b;
        rx_valid = 1'b1;
        #1;
        while (!rx_ready && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 500) fail_now("rx_accept");
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input vec_t v);
        send_byte(v.op);
        send_byte(8'h00);
        send_byte(v.len[7:0]);
        send_byte(v.len[15:8]);
        for (int i = 0; i < int'(v.npl); i++) send_byte(v.pl[i]);
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (2) @(negedge clk);
        while ((busy || tx_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_now("idle_wait");
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset();
        chk("rst_rx_ready", 64'(rx_ready), 0);
        chk("rst_tx_valid", 64'(tx_valid), 0);
        chk("rst_tx_data", 64'(tx_data), 0);
        chk("rst_alu_valid", 64'(alu_valid), 0);
        chk("rst_alu_opcode", 64'(alu_opcode), 0);
        chk("rst_alu_a", 64'(alu_a), 0);
        chk("rst_alu_b", 64'(alu_b), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_err", 64'(err), 0);
    endtask

    initial begin
        vec_t v;
        int e0;
        vecs[0]  = mk(8'hAD, 16'd12, 8, {32'd7, 32'd5}, 4, 64'h0C,
                      2, {32'd0, 32'd5, 32'd0}, {32'd0, 32'd7, 32'd5},
                      0, 1, 0);
        vecs[1]  = mk(8'hAC, 16'd16, 12,
                      {32'h80000000, 32'd3, 32'd2}, 4, 64'h0,
                      3, {32'd6, 32'd2, 32'd1},
                      {32'h80000000, 32'd3, 32'd2}, 0, 3, 0);
        vecs[2]  = mk(8'hD1, 16'd12, 8, {32'd7, 32'd100}, 4, 64'h0E,
                      1, {64'd0, 32'd100}, {64'd0, 32'd7}, 0, 2, 0);
        vecs[3]  = mk(8'hD1, 16'd8, 4, 128'h11, 0, 64'h0,
                      0, '0, '0, 1, 1, 0);
        vecs[4]  = mk(8'hAD, 16'd8, 4, 128'h11223344, 4,
                      64'h11223344, 1, {64'd0, 32'd0},
                      {64'd0, 32'h11223344}, 0, 1, 0);
        vecs[5]  = mk(8'hEC, 16'd7, 3, 128'h434241, 3, 64'h434241,
                      0, '0, '0, 0, 1, 1);
        vecs[6]  = mk(8'h55, 16'd10, 6, 128'h665544332211, 0, 64'h0,
                      0, '0, '0, 1, 1, 0);
        vecs[7]  = mk(8'hAD, 16'd12, 8, {32'd2, 32'hFFFFFFFF}, 4,
                      64'h01, 2, {32'd0, 32'hFFFFFFFF, 32'd0},
                      {32'd0, 32'd2, 32'hFFFFFFFF}, 0, 2, 0);
        vecs[8]  = mk(8'hAD, 16'd4, 0, '0, 4, 64'h0,
                      0, '0, '0, 0, 1, 0);
        vecs[9]  = mk(8'hAC, 16'd4, 0, '0, 4, 64'h01,
                      0, '0, '0, 0, 1, 0);
        vecs[10] = mk(8'hEC, 16'd4, 0, '0, 0, 64'h0,
                      0, '0, '0, 0, 1, 0);
        vecs[11] = mk(8'hAD, 16'd2, 0, '0, 4, 64'h0,
                      0, '0, '0, 0, 1, 0);
        vecs[12] = mk(8'hAD, 16'd10, 6, {16'hBEEF, 32'd5}, 4, 64'h05,
                      1, '0, {64'd0, 32'd5}, 0, 1, 0);
        vecs[13] = mk(8'hD1, 16'd12, 8, {32'd0, 32'd10}, 4,
                      64'hFFFFFFFF, 1, {64'd0, 32'd10}, '0, 0, 1, 0);
        vecs[14] = mk(8'hEC, 16'd9, 5, 128'h0504030201, 5,
                      64'h0504030201, 0, '0, '0, 0, 1, 0);
        vecs[15] = mk(8'h00, 16'd0, 0, '0, 0, 64'h0,
                      0, '0, '0, 1, 1, 0);

        rst = 1'b0;
        rx_valid = 1'b0;
        rx_data = '0;
        #12;
        check_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rx_ready_hdr0", 64'(rx_ready), 1);

        for (int k = 0; k < NV; k++) begin
            v = vecs[k];
            alu_lat = int'(v.lat);
            tog = v.tog;
            got_a.delete();
            got_b.delete();
            e0 = err_cnt;
            for (int i = 0; i < int'(v.nex); i++)
                exp_q.push_back(v.ex[i]);
            send_pkt(v);
            wait_idle();
            chk($sformatf("v%0d_err", k), 64'(err_cnt - e0),
                64'(v.err));
            chk($sformatf("v%0d_tx_left", k), 64'(exp_q.size()), 0);
            exp_q.delete();
            chk($sformatf("v%0d_alu_reqs", k), 64'(got_a.size()),
                64'(v.na));
            for (int i = 0; i < got_a.size() && i < int'(v.na); i++) begin
                chk($sformatf("v%0d_alu_a%0d", k, i), 64'(got_a[i]),
                    64'(v.ea[i]));
                chk($sformatf("v%0d_alu_b%0d", k, i), 64'(got_b[i]),
                    64'(v.eb[i]));
            end
        end

        // Reset while an AC request is outstanding.
        tog = 1'b0;
        alu_lat = 20;
        send_byte(8'hAC);
        send_byte(8'h00);
        send_byte(8'd12);
        send_byte(8'h00);
        send_byte(8'd2);
        send_byte(8'd0);
        send_byte(8'd0);
        send_byte(8'd0);
        chk("pre_rst_alu_valid", 64'(alu_valid), 1);
        chk("pre_rst_rx_ready", 64'(rx_ready), 0);
        chk("pre_rst_busy", 64'(busy), 1);
        rst = 1'b0;
        #1;
        check_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        alu_lat = 1;
        got_a.delete();
        got_b.delete();
        e0 = err_cnt;
        exp_q.push_back(8'h09);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        send_byte(8'hAD);
        send_byte(8'h00);
        send_byte(8'd8);
        send_byte(8'h00);
        send_byte(8'h09);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_idle();
        chk("post_rst_tx_left", 64'(exp_q.size()), 0);
        chk("post_rst_err", 64'(err_cnt - e0), 0);
        chk("post_rst_alu_reqs", 64'(got_a.size()), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
